// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: decodes ALUOp/funct into the 3-bit ALU control code and
// registers it with both operands in a one-entry valid/ready stage feeding
// the combinational ALU. Undecodable encodings pass downstream flagged illegal.
// Optional feature macro: ALU_CTRL_ILLEGAL_CNT_EN adds a saturating
// illegal-op counter on output illegal_cnt_o.
module alu_ctrl_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       ALUOp_i,
    input  logic [9:0]       funct_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [2:0]       ALUCtrl_o,
    output logic [WIDTH-1:0] data1_o,
    output logic [WIDTH-1:0] data2_o,
    output logic             illegal_o
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt_o
`endif
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_MUL = 3'b111;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_ITYPE  = 2'b11;

    // funct = {funct7, funct3}
    localparam logic [9:0] FN_AND = 10'b0000000_111;
    localparam logic [9:0] FN_OR  = 10'b0000000_110;
    localparam logic [9:0] FN_ADD = 10'b0000000_000;
    localparam logic [9:0] FN_SUB = 10'b0100000_000;
    localparam logic [9:0] FN_MUL = 10'b0000001_000;

    logic [2:0] dec_ctrl;
    logic       dec_illegal;
    logic       accept;

    // Downstream slot is free when empty or being drained this cycle
    assign ready_o = !valid_o || ready_i;
    // Flush drops any same-cycle issue
    assign accept  = valid_i && ready_o && !flush_i;

    // Control-code decode; unknown encodings fall back to add and raise illegal
    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        case (ALUOp_i)
            OP_MEM:    dec_ctrl = CTRL_ADD;
            OP_BRANCH: dec_ctrl = CTRL_SUB;
            OP_RTYPE: begin
                case (funct_i)
                    FN_AND:  dec_ctrl = CTRL_AND;
                    FN_OR:   dec_ctrl = CTRL_OR;
                    FN_ADD:  dec_ctrl = CTRL_ADD;
                    FN_SUB:  dec_ctrl = CTRL_SUB;
                    FN_MUL:  dec_ctrl = CTRL_MUL;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                if (funct_i[2:0] != 3'b000) begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Pipeline register: reset, then flush, accept, drain, stall in priority order
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            ALUCtrl_o <= CTRL_AND;
            data1_o   <= '0;
            data2_o   <= '0;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else if (accept) begin
            valid_o   <= 1'b1;
            ALUCtrl_o <= dec_ctrl;
            data1_o   <= data1_i;
            data2_o   <= data2_i;
            illegal_o <= dec_illegal;
        end else if (ready_i) begin
            valid_o   <= 1'b0;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    // Saturating count of accepted illegal ops; flush leaves it untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_cnt_o <= '0;
        end else if (accept && dec_illegal && (illegal_cnt_o != {CNT_W{1'b1}})) begin
            illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed-vector bench for alu_ctrl_stage; counter checks run when
// ALU_CTRL_ILLEGAL_CNT_EN is defined.
module tb_alu_ctrl_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       ALUOp_i;
    logic [9:0]       funct_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [2:0]       ALUCtrl_o;
    logic [WIDTH-1:0] data1_o;
    logic [WIDTH-1:0] data2_o;
    logic             illegal_o;
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt_o;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_ctrl_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUOp_i   (ALUOp_i),
        .funct_i   (funct_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .ALUCtrl_o (ALUCtrl_o),
        .data1_o   (data1_o),
        .data2_o   (data2_o),
        .illegal_o (illegal_o)
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        ,
        .illegal_cnt_o (illegal_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [9:0] fn,
                         input logic [31:0] d1, input logic [31:0] d2);
        valid_i = 1'b1;
        ALUOp_i = op;
        funct_i = fn;
        data1_i = d1;
        data2_i = d2;
    endtask

    logic [9:0] sweep_f [5] = '{10'b0000000_111, 10'b0000000_110, 10'b0000000_000,
                                10'b0100000_000, 10'b0000001_000};
    logic [2:0] sweep_c [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
        issue(2'b10, 10'b0000000_000, 32'hDEAD, 32'hBEEF);

        // Reset with valid_i high
        tick(); tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ctrl", 32'(ALUCtrl_o), 32'd0);
        check("rst_d1", data1_o, 32'd0);
        check("rst_d2", data2_o, 32'd0);
        check("rst_ill", 32'(illegal_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        check("rst_cnt", 32'(illegal_cnt_o), 32'd0);
`endif
        rst_i = 1'b0;
        ready_i = 1'b1;

        // R-type sweep, back to back
        for (int i = 0; i < 5; i++) begin
            issue(2'b10, sweep_f[i], 32'(i + 100), 32'(i + 200));
            tick();
            check("sweep_valid", 32'(valid_o), 32'd1);
            check("sweep_ctrl", 32'(ALUCtrl_o), 32'(sweep_c[i]));
            check("sweep_d1", data1_o, 32'(i + 100));
            check("sweep_ill", 32'(illegal_o), 32'd0);
        end

        // Other op classes
        issue(2'b00, 10'b1111111_111, 32'd1, 32'd2); tick();
        check("mem_ctrl", 32'(ALUCtrl_o), 32'b010);
        check("mem_ill", 32'(illegal_o), 32'd0);
        issue(2'b01, 10'b1111111_111, 32'd3, 32'd4); tick();
        check("br_ctrl", 32'(ALUCtrl_o), 32'b110);
        issue(2'b11, 10'b0101010_000, 32'd5, 32'd6); tick();
        check("addi_ctrl", 32'(ALUCtrl_o), 32'b010);
        check("addi_ill", 32'(illegal_o), 32'd0);
        issue(2'b11, 10'b0000000_001, 32'd7, 32'd8); tick();
        check("itype_ill", 32'(illegal_o), 32'd1);
        check("itype_ctrl", 32'(ALUCtrl_o), 32'b010);

        // Illegal R-type funct
        issue(2'b10, 10'b0000000_001, 32'd5, 32'd7); tick();
        check("ill_valid", 32'(valid_o), 32'd1);
        check("ill_ctrl", 32'(ALUCtrl_o), 32'b010);
        check("ill_flag", 32'(illegal_o), 32'd1);
        check("ill_d1", data1_o, 32'd5);
        check("ill_d2", data2_o, 32'd7);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        check("ill_cnt", 32'(illegal_cnt_o), 32'd2);
`endif

        // Stall: accept branch, then hold ready_i low with a new op pending
        issue(2'b01, 10'd0, 32'd11, 32'd22); tick();
        check("stall_load", 32'(ALUCtrl_o), 32'b110);
        ready_i = 1'b0;
        issue(2'b00, 10'd0, 32'd33, 32'd44);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(ready_o), 32'd0);
            tick();
            check("stall_valid", 32'(valid_o), 32'd1);
            check("stall_ctrl", 32'(ALUCtrl_o), 32'b110);
            check("stall_d1", data1_o, 32'd11);
            check("stall_d2", data2_o, 32'd22);
        end
        ready_i = 1'b1;
        #1;
        check("unstall_ready", 32'(ready_o), 32'd1);
        tick();
        check("unstall_valid", 32'(valid_o), 32'd1);
        check("unstall_ctrl", 32'(ALUCtrl_o), 32'b010);
        check("unstall_d1", data1_o, 32'd33);

        // Flush while holding an illegal op, with a same-cycle issue
        issue(2'b10, 10'b0000000_010, 32'd55, 32'd66); tick();
        check("pre_flush_ill", 32'(illegal_o), 32'd1);
        flush_i = 1'b1;
        issue(2'b01, 10'd0, 32'd99, 32'd98); tick();
        flush_i = 1'b0;
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_ill", 32'(illegal_o), 32'd0);
        check("flush_d1", data1_o, 32'd55);
        check("flush_ctrl", 32'(ALUCtrl_o), 32'b010);

        // No issue: outputs hold, not zeroed
        valid_i = 1'b0;
        data1_i = 32'd123;
        tick();
        check("idle_valid", 32'(valid_o), 32'd0);
        check("idle_d1", data1_o, 32'd55);

        // Drain with ready_i while nothing new arrives
        issue(2'b00, 10'd0, 32'd77, 32'd78); tick();
        valid_i = 1'b0; tick();
        check("drain_valid", 32'(valid_o), 32'd0);
        check("drain_d1", data1_o, 32'd77);

        // Reset mid-operation discards the held op
        issue(2'b01, 10'd0, 32'd88, 32'd89); tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        valid_i = 1'b0;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_d1", data1_o, 32'd0);
        check("midrst_ctrl", 32'(ALUCtrl_o), 32'd0);

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        check("cnt_after_rst", 32'(illegal_cnt_o), 32'd0);
        issue(2'b10, 10'b0000000_001, 32'd1, 32'd1); tick();
        check("cnt_one", 32'(illegal_cnt_o), 32'd1);
        flush_i = 1'b1;
        issue(2'b10, 10'b0000000_001, 32'd1, 32'd1); tick();
        flush_i = 1'b0;
        check("cnt_flush", 32'(illegal_cnt_o), 32'd1);
        for (int i = 0; i < 259; i++) begin
            tick();
        end
        check("cnt_sat", 32'(illegal_cnt_o), 32'd255);
        valid_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Producer side of the ALU control interface: decodes ALUOp and funct fields into the 3-bit ALU control code.
- Registers the code together with both operands in a one-entry valid/ready pipeline stage that drives the ALU directly.
- Sits between the ID stage and the combinational ALU.
- Flags encodings it cannot decode.

Parameters:
- WIDTH, 32, operand width in bits (data1/data2 passthrough).
- CNT_W, 8, width of illegal-op counter (used only with optional feature).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- valid_i  input  1  upstream has an op to issue
- ready_o  output  1  stage can accept an op this cycle
- ALUOp_i  input  2  main-decoder op class
- funct_i  input  10  {funct7[6:0], funct3[2:0]}
- data1_i  input  WIDTH  operand 1
- data2_i  input  WIDTH  operand 2
- flush_i  input  1  kill stored op (branch redirect)
- valid_o  output  1  registered op valid toward ALU/EX
- ready_i  input  1  downstream consumes op this cycle
- ALUCtrl_o  output  3  registered ALU control code
- data1_o  output  WIDTH  registered operand 1
- data2_o  output  WIDTH  registered operand 2
- illegal_o  output  1  registered op had undecodable funct/ALUOp

Behaviour:
- Clock and reset: one clock `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values: valid_o=0, ALUCtrl_o=3'b000, data1_o=0, data2_o=0, illegal_o=0.
- Reset takes priority over everything and may assert mid-operation; the held op is discarded.
- ready_o = !valid_o || ready_i (combinational). Full throughput of 1 op/cycle when ready_i is held high.
- Transfer in: valid_i && ready_o at the edge. Transfer out: valid_o && ready_i at the edge.
- Latency is 1 cycle: an accepted op appears on the outputs the cycle after acceptance.
- Decode (combinational from inputs, registered on accept):
  - ALUOp 00 (load/store) -> 010 add
  - ALUOp 01 (branch) -> 110 sub
  - ALUOp 10 (R-type):
    - funct 0000000_111 -> 000 and
    - 0000000_110 -> 001 or
    - 0000000_000 -> 010 add
    - 0100000_000 -> 110 sub
    - 0000001_000 -> 111 mul
  - ALUOp 11 (I-type): funct3=000 -> 010 addi; funct7 ignored.
  - Any other combination: ALUCtrl=010, illegal=1. The op is still passed downstream with valid.
- Sequential update priority, applied each edge when not in reset:
  1. flush_i=1: valid_o<=0 and illegal_o<=0; data1_o, data2_o and ALUCtrl_o hold. Any same-cycle valid_i is dropped and not accepted.
  2. else if valid_i && ready_o: load all outputs, valid_o<=1.
  3. else if ready_i: valid_o<=0, other outputs hold.
  4. else: hold all outputs (stall).
- Stall: while valid_o && !ready_i, all outputs are stable and ready_o=0.
- Simultaneous out+in (valid_o && ready_i && valid_i): the new op replaces the old in the same edge with no bubble.
- Inputs are not sampled when valid_i=0. Output data is don't-care-stable when valid_o=0 and is held, not zeroed.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_CNT_EN.
- When defined:
  - adds output illegal_cnt_o [CNT_W-1:0], reset to 0;
  - increments on each accepted op whose decode is illegal;
  - saturates at all-ones and does not wrap;
  - flush does not decrement or clear it.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_i 2 cycles with valid_i=1 -> valid_o=0, ALUCtrl_o=000, data1_o=data2_o=0, illegal_o=0, ready_o=1.
- Decode sweep: issue ALUOp=10 with funct 0000000_111, 0000000_110, 0000000_000, 0100000_000, 0000001_000 back-to-back with ready_i=1 -> ALUCtrl_o sequence 000, 001, 010, 110, 111 one cycle later each, valid_o continuously 1.
- Illegal: ALUOp=10, funct=0000000_001, data1=5, data2=7 -> next cycle valid_o=1, ALUCtrl_o=010, illegal_o=1, data1_o=5, data2_o=7; with macro, illegal_cnt_o 0->1.
- Stall: accept op (ALUOp=01) then ready_i=0 for 3 cycles while valid_i=1 with new data -> ALUCtrl_o=110 and operands hold, ready_o=0. Raise ready_i -> new op loaded next edge with no gap.
- Flush: flush_i=1 in same cycle as valid_i=1, valid_o=1 -> next cycle valid_o=0, illegal_o=0, new op not captured.
- Saturation (macro on, CNT_W=8): 260 accepted illegal ops -> illegal_cnt_o=255, no wrap.
